// File: rtl/ysyx_22040386_dsram.sv
// ysyx_22040386_dsram: data-memory responder for the MEM stage.
// Takes one load/store at a time, performs it on an internal array of
// 64-bit doublewords after LATENCY cycles, and returns the full aligned
// doubleword (or an error for out-of-range addresses).
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_req_valid/o_req_ready  request handshake
//   i_req_wen             1 = store, 0 = load
//   i_req_addr            byte address, bits [2:0] ignored
//   i_req_wdata/wmask     lane-aligned store data and byte enables
//   o_rsp_valid/i_rsp_ready  response handshake
//   o_rsp_rdata           loaded doubleword (0 for stores and errors)
//   o_rsp_err             address outside the array
module ysyx_22040386_dsram #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wen,
    input  logic [63:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    input  logic [7:0]  i_req_wmask,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [63:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [60:0] BASE_DW  = BASE_ADDR[63:3];

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        commit, rsp_done;

    logic        hold_wen_q;
    logic [60:0] hold_dw_q;
    logic [63:0] hold_wdata_q;
    logic [7:0]  hold_wmask_q;

    logic        rsp_valid_q, rsp_err_q;
    logic [63:0] rsp_rdata_q;

    logic [63:0] mem [DEPTH];

    // Byte offset within a doubleword carries no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_req_addr[2:0];

    // With LATENCY == 1 the commit edge is the accept edge, so the access
    // must use the live request rather than the holding registers.
    logic        acc_wen;
    logic [60:0] acc_dw;
    logic [63:0] acc_wdata;
    logic [7:0]  acc_wmask;

    always_comb begin
        if (state_q == StIdle) begin
            acc_wen   = i_req_wen;
            acc_dw    = i_req_addr[63:3];
            acc_wdata = i_req_wdata;
            acc_wmask = i_req_wmask;
        end else begin
            acc_wen   = hold_wen_q;
            acc_dw    = hold_dw_q;
            acc_wdata = hold_wdata_q;
            acc_wmask = hold_wmask_q;
        end
    end

    // Range check on doubleword addresses; the lower-bound test keeps the
    // subtraction from wrapping into a valid index.
    logic [60:0]           dw_off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] index;

    assign dw_off   = acc_dw - BASE_DW;
    assign in_range = (acc_dw >= BASE_DW) && ((dw_off >> DEPTH_LOG2) == '0);
    assign index    = dw_off[DEPTH_LOG2-1:0];

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit   = 1'b0;
        rsp_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = StResp;
                        cnt_d   = '0;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    state_d  = StIdle;
                    rsp_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            hold_wen_q   <= 1'b0;
            hold_dw_q    <= '0;
            hold_wdata_q <= '0;
            hold_wmask_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == StIdle) && i_req_valid) begin
                hold_wen_q   <= i_req_wen;
                hold_dw_q    <= i_req_addr[63:3];
                hold_wdata_q <= i_req_wdata;
                hold_wmask_q <= i_req_wmask;
            end
            if (commit) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= ~in_range;
                rsp_rdata_q <= (!acc_wen && in_range) ? mem[index] : '0;
            end else if (rsp_done) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end
        end
    end

    // Array contents are not reset. Writes are blocked while reset is held.
    always_ff @(posedge i_clk) begin
        if (commit && acc_wen && in_range && !i_rst) begin
            for (int i = 0; i < 8; i++) begin
                if (acc_wmask[i]) begin
                    mem[index][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_req_ready = (state_q == StIdle) && !i_rst;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_22040386_dsram.sv
// Directed bench for ysyx_22040386_dsram. Two instances share the request
// and response-ready signals: dut2 (LATENCY=2) for most vectors, dut3
// (LATENCY=3) for the reset-during-WAIT case; sel picks the active one.
module tb_ysyx_22040386_dsram;

    logic        clk = 1'b0;
    logic        rst2, rst3, sel;
    logic        req_valid, wen, rsp_ready;
    logic [63:0] addr, wdata;
    logic [7:0]  wmask;

    logic        ready2, ready3, rv2, rv3, err2, err3;
    logic [63:0] rd2, rd3;

    logic        ready_m, rsp_valid_m, rsp_err_m;
    logic [63:0] rsp_rdata_m;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_22040386_dsram #(.LATENCY(2)) u_dut2 (
        .i_clk       (clk),
        .i_rst       (rst2),
        .i_req_valid (req_valid & ~sel),
        .o_req_ready (ready2),
        .i_req_wen   (wen),
        .i_req_addr  (addr),
        .i_req_wdata (wdata),
        .i_req_wmask (wmask),
        .o_rsp_valid (rv2),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rd2),
        .o_rsp_err   (err2)
    );

    ysyx_22040386_dsram #(.LATENCY(3)) u_dut3 (
        .i_clk       (clk),
        .i_rst       (rst3),
        .i_req_valid (req_valid & sel),
        .o_req_ready (ready3),
        .i_req_wen   (wen),
        .i_req_addr  (addr),
        .i_req_wdata (wdata),
        .i_req_wmask (wmask),
        .o_rsp_valid (rv3),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rd3),
        .o_rsp_err   (err3)
    );

    assign ready_m     = sel ? ready3 : ready2;
    assign rsp_valid_m = sel ? rv3 : rv2;
    assign rsp_err_m   = sel ? err3 : err2;
    assign rsp_rdata_m = sel ? rd3 : rd2;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction with rsp_ready=1. lat counts cycles from the
    // accept cycle to the first cycle with rsp_valid high.
    task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] m, output logic [63:0] rdata,
                        output logic err, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        wen       = w;
        addr      = a;
        wdata     = d;
        wmask     = m;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid_m && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rsp_rdata_m;
        err   = rsp_err_m;
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;

    logic [63:0] rdata;
    logic        err;
    int          lat;

    initial begin
        sel       = 1'b0;
        rsp_ready = 1'b1;
        rst2      = 1'b1;
        rst3      = 1'b1;
        // Request held high throughout reset.
        req_valid = 1'b1;
        wen       = 1'b1;
        addr      = 64'h8000_0000;
        wdata     = D0;
        wmask     = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", ready_m, 0);
        check_eq("rst_valid", rsp_valid_m, 0);
        check_eq("rst_rdata", rsp_rdata_m, 0);
        check_eq("rst_err", rsp_err_m, 0);
        @(negedge clk);
        rst2 = 1'b0;
        rst3 = 1'b0;
        #1;
        check_eq("post_rst_ready", ready_m, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("first_acc_valid_low", rsp_valid_m, 0);
        @(posedge clk);
        #1;
        check_eq("first_acc_valid", rsp_valid_m, 1);
        check_eq("first_acc_rdata", rsp_rdata_m, 0);
        check_eq("first_acc_err", rsp_err_m, 0);
        @(posedge clk);
        #1;
        check_eq("first_hs_valid", rsp_valid_m, 0);

        // Full store then load.
        xact(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, rdata, err, lat);
        check_eq("st_lat", 64'(lat), 2);
        check_eq("st_rdata", rdata, 0);
        check_eq("st_err", err, 0);
        check_eq("st_hs_valid", rsp_valid_m, 0);
        check_eq("st_hs_ready", ready_m, 1);
        xact(1'b0, 64'h8000_0010, 64'h0, 8'h00, rdata, err, lat);
        check_eq("ld_lat", 64'(lat), 2);
        check_eq("ld_rdata", rdata, 64'h1122_3344_5566_7788);
        check_eq("ld_err", err, 0);
        xact(1'b0, 64'h8000_0015, 64'h0, 8'h00, rdata, err, lat);
        check_eq("ld_lowbits", rdata, 64'h1122_3344_5566_7788);

        // Partial writes and empty mask.
        xact(1'b1, 64'h8000_0018, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, rdata, err, lat);
        xact(1'b1, 64'h8000_0018, 64'hBBBB_BBBB_BBBB_BBBB, 8'hF0, rdata, err, lat);
        xact(1'b0, 64'h8000_0018, 64'h0, 8'h00, rdata, err, lat);
        check_eq("partial", rdata, 64'hBBBB_BBBB_AAAA_AAAA);
        xact(1'b1, 64'h8000_0018, 64'hCCCC_CCCC_CCCC_CCCC, 8'h00, rdata, err, lat);
        check_eq("mask0_err", err, 0);
        xact(1'b0, 64'h8000_0018, 64'h0, 8'h00, rdata, err, lat);
        check_eq("mask0_unchanged", rdata, 64'hBBBB_BBBB_AAAA_AAAA);

        // Bounds.
        xact(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, rdata, err, lat);
        check_eq("below_err", err, 1);
        check_eq("below_rdata", rdata, 0);
        xact(1'b0, 64'h8000_2000, 64'h0, 8'h00, rdata, err, lat);
        check_eq("past_end_err", err, 1);
        check_eq("past_end_rdata", rdata, 0);
        xact(1'b1, 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, rdata, err, lat);
        check_eq("past_end_st_err", err, 1);
        xact(1'b0, 64'h8000_0000, 64'h0, 8'h00, rdata, err, lat);
        check_eq("base_unchanged", rdata, D0);
        xact(1'b1, 64'h8000_1FF8, 64'h5555_6666_7777_8888, 8'hFF, rdata, err, lat);
        xact(1'b0, 64'h8000_1FF8, 64'h0, 8'h00, rdata, err, lat);
        check_eq("last_err", err, 0);
        check_eq("last_rdata", rdata, 64'h5555_6666_7777_8888);

        // Backpressure: a second request stays asserted during RESP.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        wen       = 1'b0;
        addr      = 64'h8000_0010;
        @(posedge clk);
        #1;
        addr = 64'h8000_0018;
        @(posedge clk);
        #1;
        check_eq("bp_valid0", rsp_valid_m, 1);
        check_eq("bp_rdata0", rsp_rdata_m, 64'h1122_3344_5566_7788);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_valid", rsp_valid_m, 1);
            check_eq("bp_rdata", rsp_rdata_m, 64'h1122_3344_5566_7788);
            check_eq("bp_err", rsp_err_m, 0);
            check_eq("bp_ready", ready_m, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_hs_valid", rsp_valid_m, 0);
        check_eq("bp_hs_rdata", rsp_rdata_m, 0);
        check_eq("bp_hs_ready", ready_m, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("bp_next_accepted", ready_m, 0);
        @(posedge clk);
        #1;
        check_eq("bp_next_valid", rsp_valid_m, 1);
        check_eq("bp_next_rdata", rsp_rdata_m, 64'hBBBB_BBBB_AAAA_AAAA);
        @(posedge clk);
        #1;

        // Reset during WAIT on the LATENCY=3 instance.
        sel = 1'b1;
        xact(1'b1, 64'h8000_0020, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, rdata, err, lat);
        check_eq("l3_lat", 64'(lat), 3);
        @(negedge clk);
        req_valid = 1'b1;
        wen       = 1'b1;
        addr      = 64'h8000_0020;
        wdata     = 64'hDEAD_DEAD_DEAD_DEAD;
        wmask     = 8'hFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        rst3 = 1'b1;
        #1;
        check_eq("l3_rst_ready", ready_m, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("l3_no_rsp", rsp_valid_m, 0);
        end
        xact(1'b0, 64'h8000_0020, 64'h0, 8'h00, rdata, err, lat);
        check_eq("l3_ld_rdata", rdata, 64'h0F0F_0F0F_0F0F_0F0F);
        check_eq("l3_ld_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040386_dsram.md
# ysyx_22040386_dsram

Data-memory responder for the pipeline's MEM stage. Accepts one load or store request at a time over a valid/ready request channel and performs it on an internal doubleword array after a fixed latency. Returns the full aligned 64-bit doubleword, or an error, over a valid/ready response channel. Byte/half/word extraction and sign extension stay in the requester. This block replaces the zero-latency DPI memory path for synthesizable builds.

## Interface
Parameters:
- DEPTH_LOG2, default 10: number of address bits in the array index; the array holds 2^DEPTH_LOG2 64-bit doublewords (8 KiB at the default).
- BASE_ADDR, default 64'h8000_0000: byte address of doubleword index 0.
- LATENCY, default 2: cycles from request accept to o_rsp_valid. Legal values are 1 to 15.

Ports (the reset is asynchronous and active-high; one clock domain):
- i_clk, input, 1: the single clock.
- i_rst, input, 1: asynchronous active-high reset.
- i_req_valid, input, 1: request present.
- o_req_ready, output, 1: responder can accept a request.
- i_req_wen, input, 1: 1 means store, 0 means load.
- i_req_addr, input, 64: byte address; bits [2:0] are ignored.
- i_req_wdata, input, 64: store data, already lane-aligned.
- i_req_wmask, input, 8: byte enables; bit i covers wdata[8i+7:8i].
- o_rsp_valid, output, 1: response present.
- i_rsp_ready, input, 1: requester accepts the response.
- o_rsp_rdata, output, 64: doubleword read by a load. It is 0 for stores and for errors.
- o_rsp_err, output, 1: the address was outside the array.

## Operation
- There are three states:
  - IDLE drives o_req_ready=1.
  - WAIT drives o_req_ready=0.
  - RESP drives o_req_ready=0 and o_rsp_valid=1.
- Request accept happens when i_req_valid and o_req_ready are both high at a rising edge. On accept:
  - Capture wen, addr, wdata and wmask into holding registers.
  - Load the latency counter with LATENCY-1.
  - Go to RESP if LATENCY is 1, otherwise go to WAIT.
- In WAIT, the counter decrements on every edge. On the edge where the counter is 1 (going to 0), the state moves to RESP.
- The commit edge is the edge that enters RESP. On that edge the array access happens using the held request:
  - Index is (addr − BASE_ADDR) >> 3, taking DEPTH_LOG2 bits.
  - The access is in range when BASE_ADDR ≤ addr < BASE_ADDR + 8·2^DEPTH_LOG2. The unsigned subtraction must not be allowed to wrap.
  - In-range store: write each byte i whose wmask[i]=1 and leave the other bytes unchanged. Set rdata=0 and err=0. A store with wmask=0 completes normally and changes nothing.
  - In-range load: set rdata to array[index] and err=0.
  - Out of range: no array write, rdata=0, err=1.
- RESP holds o_rsp_valid, o_rsp_rdata and o_rsp_err stable until i_rsp_ready=1. On that edge the block returns to IDLE and clears o_rsp_valid, o_rsp_rdata and o_rsp_err to 0.
- Only one request is outstanding at a time. There is no accept in the same cycle as a response handshake.
- Request inputs are ignored outside IDLE, and a requester that changes them outside IDLE has no effect.
- A store followed by a load to the same address returns the stored bytes, because the commit happens before the next accept.
- Array contents are not reset. They are undefined until written.

## Timing
- Reset, asynchronous: state=IDLE, counter=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0. o_req_ready=0 while i_rst=1, and 1 in the first cycle after i_rst deasserts.
- Reset mid-operation:
  - In WAIT, the pending request is dropped and no array write occurs.
  - In RESP, the response is lost; the write has already committed.
- Latency: accept at edge N gives o_rsp_valid=1 in the cycle after edge N+LATENCY−1, which is LATENCY cycles after accept.
- Minimum occupancy per request is LATENCY+1 cycles when i_rsp_ready is held at 1. Each extra low cycle of i_rsp_ready adds one cycle.
- All outputs are registered except o_req_ready, which is decoded from state and i_rst only, with no combinational path from any input.
- The array is a single synchronous-write memory with the read registered at the commit edge. It is inferable as one-port SRAM.

## Test plan
- Reset with i_req_valid=1 held high, release i_rst → the first accept happens in the cycle after deassert; no response during reset; o_rsp_rdata=0 and o_rsp_err=0.
- LATENCY=2, i_rsp_ready=1: store addr=0x8000_0010, wdata=0x1122334455667788, wmask=0xFF, then load the same address → each o_rsp_valid rises exactly 2 cycles after its accept; the load returns 0x1122334455667788 with err=0; the store response has rdata=0.
- Partial write: store 0xAAAA… with wmask=0x0F, then store 0xBBBB… with wmask=0xF0, then load → 0xBBBBBBBBAAAAAAAA. A further store with wmask=0x00 followed by a load → value unchanged.
- Bounds:
  - Load at 0x7FFF_FFF8 → err=1, rdata=0.
  - Load at BASE+0x2000 (one past the end at the default depth) → err=1.
  - Store at BASE+0x2000 → err=1, and a load at 0x8000_0000 is unchanged.
  - Load at BASE+0x1FF8 → err=0.
- Backpressure: hold i_rsp_ready=0 for 5 cycles during RESP → o_rsp_valid, o_rsp_rdata and o_rsp_err stay stable; o_req_ready=0 throughout; a new i_req_valid is not accepted until the cycle after the response handshake.
- Assert i_rst during WAIT of a store to 0x8000_0020 with LATENCY=3 → no response after reset, and a later load of 0x8000_0020 returns its pre-store value.
